lives_display_ctrl: RTL and testbench

- Sequences on-screen lives display for the 160x120 VGA adapter.
- Starts the label drawer (word "LIVE") and forwards its pixels.
- Draws one filled square per remaining life, then erases the rightmost square on each lost life.
- Owns the lives count and game_over; sole driver of the adapter x/y/colour/plot port.

---
 rtl/lives_display_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_lives_display_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lives_display_ctrl.sv
// lives_display_ctrl: sequences the lives HUD on the 160x120 VGA adapter.
// Launches the "LIVE" label drawer and forwards its pixels, then draws one
// filled box per life and erases the rightmost box on every lost life.
// It is the only driver of the adapter pixel port, and it owns the lives count
// and game_over.
// Optional build macro LIVES_QUEUE_EN: lost-life pulses that arrive while busy
// are queued in a saturating counter. Without the macro a single pending flag
// is kept, and any extra pulses are dropped.
module lives_display_ctrl #(
    parameter int unsigned MAX_LIVES    = 4,
    parameter int unsigned BOX_X0       = 40,
    parameter int unsigned BOX_Y        = 10,
    parameter int unsigned BOX_SIZE     = 5,
    parameter int unsigned BOX_PITCH    = 8,
    parameter logic [2:0]  LABEL_COLOUR = 3'b111,
    parameter logic [2:0]  LIVE_COLOUR  = 3'b100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       lose_life,
    input  logic [7:0] label_x,
    input  logic [6:0] label_y,
    input  logic       label_plot,
    input  logic       label_done,
    output logic       label_start,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic [2:0] lives,
    output logic       busy,
    output logic       game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LABEL,
        S_BOX,
        S_READY,
        S_ERASE,
        S_OVER
    } state_t;

`ifdef LIVES_QUEUE_EN
    localparam int PW = 3;
`else
    localparam int PW = 1;
`endif

    state_t          state_q, state_d;
    logic [2:0]      lives_q, lives_d;
    logic [PW-1:0]   pend_q, pend_d;
    logic [2:0]      idx_q, idx_d;
    logic [3:0]      px_q, px_d;
    logic [3:0]      py_q, py_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      col_q, col_d;
    logic            plot_q, plot_d;
    logic            lstart_q, lstart_d;

    logic [7:0]      box_x;
    logic [6:0]      box_y;
    logic            last_px, last_py;
    logic            pend_nz;
    logic [PW-1:0]   pend_inc, pend_dec;
    logic            busy_st;

    // Pixel address of the current sweep position, plus the end-of-row and end-of-box flags.
    always_comb begin
        box_x   = 8'(BOX_X0) + 8'(idx_q) * 8'(BOX_PITCH) + 8'(px_q);
        box_y   = 7'(BOX_Y) + 7'(py_q);
        last_px = (px_q == 4'(BOX_SIZE - 1));
        last_py = (py_q == 4'(BOX_SIZE - 1));
        busy_st = (state_q == S_LABEL) || (state_q == S_BOX) || (state_q == S_ERASE);
        pend_nz = (pend_q != '0);
    end

    // Record or consume one pending life loss; the queued build saturates at MAX_LIVES.
`ifdef LIVES_QUEUE_EN
    always_comb begin
        pend_inc = (pend_q == 3'(MAX_LIVES)) ? pend_q : pend_q + 3'd1;
        pend_dec = pend_q - 3'd1;
    end
`else
    always_comb begin
        pend_inc = 1'b1;
        pend_dec = 1'b0;
    end
`endif

    // State register and registered adapter outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            lives_q  <= 3'(MAX_LIVES);
            pend_q   <= '0;
            idx_q    <= '0;
            px_q     <= '0;
            py_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            col_q    <= '0;
            plot_q   <= 1'b0;
            lstart_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            pend_q   <= pend_d;
            idx_q    <= idx_d;
            px_q     <= px_d;
            py_q     <= py_d;
            x_q      <= x_d;
            y_q      <= y_d;
            col_q    <= col_d;
            plot_q   <= plot_d;
            lstart_q <= lstart_d;
        end
    end

    // Next state, box sweep counters, lives bookkeeping, and the pixel presented next cycle.
    always_comb begin
        state_d  = state_q;
        lives_d  = lives_q;
        pend_d   = pend_q;
        idx_d    = idx_q;
        px_d     = px_q;
        py_d     = py_q;
        x_d      = x_q;
        y_d      = y_q;
        col_d    = col_q;
        plot_d   = 1'b0;
        lstart_d = 1'b0;

        // Loss during a draw is deferred until the next READY cycle.
        if (busy_st && lose_life) pend_d = pend_inc;

        // Box sweep: px runs fastest, then py. Erase uses the same walk.
        if (state_q == S_BOX || state_q == S_ERASE) begin
            x_d    = box_x;
            y_d    = box_y;
            plot_d = 1'b1;
            if (!last_px) begin
                px_d = px_q + 4'd1;
            end else begin
                px_d = '0;
                if (!last_py) begin
                    py_d = py_q + 4'd1;
                end else begin
                    py_d = '0;
                end
            end
        end

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start) begin
                    state_d  = S_LABEL;
                    lstart_d = 1'b1;
                    lives_d  = 3'(MAX_LIVES);
                    pend_d   = '0;
                end
            end
            S_LABEL: begin
                x_d    = label_x;
                y_d    = label_y;
                col_d  = LABEL_COLOUR;
                plot_d = label_plot;
                if (label_done) begin
                    state_d = S_BOX;
                    idx_d   = '0;
                    px_d    = '0;
                    py_d    = '0;
                end
            end
            S_BOX: begin
                col_d = LIVE_COLOUR;
                if (last_px && last_py) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == lives_q - 3'd1) state_d = S_READY;
                end
            end
            S_READY: begin
                if ((lose_life || pend_nz) && lives_q != 3'd0) begin
                    lives_d = lives_q - 3'd1;
                    idx_d   = lives_q - 3'd1;
                    px_d    = '0;
                    py_d    = '0;
                    state_d = S_ERASE;
                    // A new pulse and a pending one together count as two losses.
                    // One is serviced now and the other stays pending.
                    if (pend_nz && !lose_life) pend_d = pend_dec;
                end
            end
            S_ERASE: begin
                col_d = 3'b000;
                if (last_px && last_py) begin
                    state_d = (lives_q == 3'd0) ? S_OVER : S_READY;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign x           = x_q;
    assign y           = y_q;
    assign colour      = col_q;
    assign plot        = plot_q;
    assign label_start = lstart_q;
    assign lives       = lives_q;
    assign busy        = busy_st;
    assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_lives_display_ctrl.sv
// Bench for lives_display_ctrl. A negedge monitor captures every plotted
// pixel. Expected pixel streams are built directly from the box geometry and
// compared against that capture.
module tb_lives_display_ctrl;

    localparam int MAXL = 4;
    localparam int X0 = 40, Y0 = 10, SZ = 5, PITCH = 8;

    logic       clk = 1'b0;
    logic       reset_n, start, lose_life, label_plot, label_done;
    logic [7:0] label_x;
    logic [6:0] label_y;
    logic       label_start, plot, busy, game_over;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour, lives;

    int checks = 0, errors = 0;
    logic [17:0] cap[$];
    logic [17:0] exp_q[$];

    typedef struct {
        int exp_lives;
        int exp_box;
        int exp_go;
        int n_plots;
    } vec_t;

    vec_t tbl[4];

    lives_display_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .lose_life(lose_life),
        .label_x(label_x), .label_y(label_y), .label_plot(label_plot),
        .label_done(label_done), .label_start(label_start), .x(x), .y(y),
        .colour(colour), .plot(plot), .lives(lives), .busy(busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (reset_n && plot) cap.push_back({x, y, colour});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, int act, int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_stream(string nm);
        int bad = -1;
        int n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        checks++;
        for (int i = 0; i < n; i++) if (bad < 0 && cap[i] !== exp_q[i]) bad = i;
        if (bad >= 0 || cap.size() != exp_q.size()) begin
            errors++;
            if (bad >= 0)
                $display("FAIL %s: pixel %0d got %h expected %h (sizes %0d/%0d)",
                         nm, bad, cap[bad], exp_q[bad], cap.size(), exp_q.size());
            else
                $display("FAIL %s: got %0d pixels expected %0d", nm, cap.size(), exp_q.size());
        end
        cap.delete();
        exp_q.delete();
    endtask

    task automatic push_box(int i, logic [2:0] c);
        for (int py = 0; py < SZ; py++)
            for (int px = 0; px < SZ; px++)
                exp_q.push_back({8'(X0 + i * PITCH + px), 7'(Y0 + py), c});
    endtask

    task automatic wait_quiet(int budget, string nm);
        int q = 0, n = 0;
        while (q < 3 && n < budget) begin
            step();
            n++;
            q = busy ? 0 : q + 1;
        end
        chk({nm, " timeout"}, int'(q >= 3), 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        cap.delete();
        exp_q.delete();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("label_start pulse", int'(label_start), 1);
        chk("busy in label", int'(busy), 1);
        chk("lives reload", int'(lives), MAXL);
        step();
        chk("label_start drop", int'(label_start), 0);
    endtask

    task automatic run_label(int n, bit rnd);
        for (int i = 0; i < n; i++) begin
            label_x    = 8'($urandom_range(0, 159));
            label_y    = 7'($urandom_range(0, 119));
            label_plot = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (label_plot) exp_q.push_back({label_x, label_y, 3'b111});
            step();
        end
        label_plot = 1'b0;
        label_done = 1'b1;
        step();
        label_done = 1'b0;
    endtask

    task automatic draw_all(int n, bit rnd);
        do_start();
        run_label(n, rnd);
        for (int i = 0; i < MAXL; i++) push_box(i, 3'b100);
        wait_quiet(400, "draw");
        chk_stream("draw stream");
        chk("lives after draw", int'(lives), MAXL);
        chk("busy after draw", int'(busy), 0);
        chk("game_over after draw", int'(game_over), 0);
    endtask

    task automatic pulse_lose();
        lose_life = 1'b1;
        step();
        lose_life = 1'b0;
    endtask

    initial begin
        int exp_l;
        reset_n = 1'b0; start = 1'b0; lose_life = 1'b0;
        label_x = '0; label_y = '0; label_plot = 1'b0; label_done = 1'b0;
        tbl[0] = '{2, 2, 0, 25};
        tbl[1] = '{1, 1, 0, 25};
        tbl[2] = '{0, 0, 1, 25};
        tbl[3] = '{0, 0, 1, 0};

        // Reset values.
        step();
        step();
        chk("rst x", int'(x), 0);
        chk("rst y", int'(y), 0);
        chk("rst colour", int'(colour), 0);
        chk("rst plot", int'(plot), 0);
        chk("rst label_start", int'(label_start), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst game_over", int'(game_over), 0);
        chk("rst lives", int'(lives), MAXL);
        reset_n = 1'b1;
        step();

        // Scenario 1: full draw.
        draw_all(30, 1'b0);

        // Scenario 2: one life lost in READY.
        pulse_lose();
        chk("lives after loss", int'(lives), 3);
        chk("busy in erase", int'(busy), 1);
        push_box(3, 3'b000);
        wait_quiet(200, "erase3");
        chk_stream("erase box3");

        // Scenario 3: spaced losses down to game over, then one extra pulse.
        for (int k = 0; k < 4; k++) begin
            repeat (30) step();
            pulse_lose();
            if (tbl[k].n_plots > 0) push_box(tbl[k].exp_box, 3'b000);
            wait_quiet(200, "table erase");
            chk_stream("table stream");
            chk("table lives", int'(lives), tbl[k].exp_lives);
            chk("table game_over", int'(game_over), tbl[k].exp_go);
        end

        // Scenario 6: restart from OVER, then a start in READY is ignored.
        draw_all(30, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("ready start no pulse", int'(label_start), 0);
        chk("ready start no busy", int'(busy), 0);
        repeat (10) step();
        chk_stream("ready start no plots");
        chk("ready start lives", int'(lives), MAXL);

        // Scenario 4: three losses during the initial box draw.
        do_reset();
        do_start();
        run_label(10, 1'b1);
        for (int i = 0; i < MAXL; i++) push_box(i, 3'b100);
        repeat (5) step();
        pulse_lose();
        repeat (20) step();
        pulse_lose();
        repeat (20) step();
        pulse_lose();
        push_box(3, 3'b000);
`ifdef LIVES_QUEUE_EN
        push_box(2, 3'b000);
        push_box(1, 3'b000);
        exp_l = 1;
`else
        exp_l = 3;
`endif
        wait_quiet(600, "pending");
        chk_stream("pending stream");
        chk("pending lives", int'(lives), exp_l);

        // Scenario 5: asynchronous reset in the middle of an erase.
        pulse_lose();
        repeat (12) step();
        chk("busy before reset", int'(busy), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async plot", int'(plot), 0);
        chk("async x", int'(x), 0);
        chk("async y", int'(y), 0);
        chk("async colour", int'(colour), 0);
        chk("async busy", int'(busy), 0);
        chk("async game_over", int'(game_over), 0);
        chk("async lives", int'(lives), MAXL);
        step();
        reset_n = 1'b1;
        step();
        chk("idle after reset busy", int'(busy), 0);
        cap.delete();

        // Random label traffic and spaced losses against a lives/box model.
        for (int it = 0; it < 3; it++) begin
            int np, lm;
            do_reset();
            draw_all($urandom_range(5, 40), 1'b1);
            np = $urandom_range(1, 6);
            lm = MAXL;
            for (int k = 0; k < np; k++) begin
                repeat ($urandom_range(35, 60)) step();
                pulse_lose();
                if (lm > 0) begin
                    lm--;
                    push_box(lm, 3'b000);
                end
                wait_quiet(200, "rand erase");
            end
            chk_stream("rand stream");
            chk("rand lives", int'(lives), lm);
            chk("rand game_over", int'(game_over), int'(lm == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
